// File: rtl/xc2_chunk_adder.sv
// Multi-cycle add/subtract unit: adds one CHUNK-bit slice per clock, LSB first,
// with a registered inter-chunk carry, between valid/ready producer and consumer.
module xc2_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_badParams
      $error("xc2_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_outValid;

  logic             w_accept;
  logic             w_lastStep;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_chunkSum;
  logic             w_msbCarryIn;

  assign w_accept   = in_valid & in_ready;
  assign w_lastStep = (r_idx == IDXW'(STEPS - 1));

  // One slice of the effective addition; b is already inverted for subtract.
  assign w_aChunk     = r_a[r_idx*CHUNK +: CHUNK];
  assign w_bChunk     = r_b[r_idx*CHUNK +: CHUNK];
  assign w_chunkSum   = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_msbCarryIn = w_aChunk[CHUNK-1] ^ w_bChunk[CHUNK-1] ^ w_chunkSum[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_nextState = RUN;
      end
      RUN: begin
        if (w_lastStep) w_nextState = DONE;
      end
      DONE: begin
        if (out_ready) w_nextState = in_valid ? RUN : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // in_ready looks through to out_ready so DONE can overlap the next accept.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= (w_nextState == DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= cin ^ sub;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_sum[r_idx*CHUNK +: CHUNK] <= w_chunkSum[CHUNK-1:0];
        r_carry                     <= w_chunkSum[CHUNK];
        if (w_lastStep) begin
          r_cout <= w_chunkSum[CHUNK];
          r_ovf  <= w_msbCarryIn ^ w_chunkSum[CHUNK];
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
